// File: rtl/rf_writeback_if.sv
// Bundles the ALU result, load handshake, register-file write port and
// decode hazard query signals of rf_writeback.
interface rf_writeback_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LQ_DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wr;
    logic [DATA_W-1:0] rf_wd;
    logic [ADDR_W-1:0] q_r1;
    logic [ADDR_W-1:0] q_r2;
    logic              pend1;
    logic              pend2;
    logic [CNT_W-1:0]  lq_count;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_r1, q_r2,
        input  ld_ready, rf_we, rf_wr, rf_wd, pend1, pend2, lq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_r1, q_r2,
        output ld_ready, rf_we, rf_wr, rf_wd, pend1, pend2, lq_count
    );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write port driver: merges never-stalled ALU results with an
// in-order load queue, drops x0 writes and kills loads overtaken by the ALU.
module rf_writeback #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LQ_DEPTH = 2
) (
    input logic           clk,
    input logic           rst_n,
    rf_writeback_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]   lq_rd   [LQ_DEPTH];
    logic [DATA_W-1:0]   lq_data [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] lq_live;
    logic [CNT_W-1:0]    head;
    logic [CNT_W-1:0]    tail;

    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             alu_wr;
    logic             push;
    logic             push_live;
    logic             pop;
    logic             head_live;
    logic             hit1;
    logic             hit2;

    assign head_idx  = head[PTR_W-1:0];
    assign tail_idx  = tail[PTR_W-1:0];
    assign count     = tail - head;
    assign full      = (count == CNT_W'(LQ_DEPTH));
    assign empty     = (count == '0);
    assign alu_wr    = bus.alu_valid && (bus.alu_rd != '0);
    assign push      = bus.ld_valid && bus.ld_ready && (bus.ld_rd != '0);
    // A same-cycle ALU result to the same register is younger, so the load is born dead.
    assign push_live = !(bus.alu_valid && (bus.alu_rd == bus.ld_rd));
    assign pop       = !alu_wr && !empty;
    assign head_live = lq_live[head_idx];

    assign bus.ld_ready = rst_n && !full;
    assign bus.lq_count = count;

    // Hazard lookup against live entries only.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (lq_live[PTR_W'(i)] && (lq_rd[PTR_W'(i)] == bus.q_r1)) hit1 = 1'b1;
            if (lq_live[PTR_W'(i)] && (lq_rd[PTR_W'(i)] == bus.q_r2)) hit2 = 1'b1;
        end
    end

    assign bus.pend1 = hit1 && (bus.q_r1 != '0);
    assign bus.pend2 = hit2 && (bus.q_r2 != '0);

    // Queue payload storage; validity is tracked separately by lq_live.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[tail_idx]   <= bus.ld_rd;
            lq_data[tail_idx] <= bus.ld_data;
        end
    end

    // Pointers and live bits; later assignments (pop, push) override the kill sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lq_live <= '0;
            head    <= '0;
            tail    <= '0;
        end else begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                if (alu_wr && (lq_rd[PTR_W'(i)] == bus.alu_rd)) lq_live[PTR_W'(i)] <= 1'b0;
            end
            if (pop) begin
                lq_live[head_idx] <= 1'b0;
                head              <= head + CNT_W'(1);
            end
            if (push) begin
                lq_live[tail_idx] <= push_live;
                tail              <= tail + CNT_W'(1);
            end
        end
    end

    // Registered write port: ALU first, then queue head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rf_we <= 1'b0;
            bus.rf_wr <= '0;
            bus.rf_wd <= '0;
        end else if (alu_wr) begin
            bus.rf_we <= 1'b1;
            bus.rf_wr <= bus.alu_rd;
            bus.rf_wd <= bus.alu_data;
        end else if (pop && head_live) begin
            bus.rf_we <= 1'b1;
            bus.rf_wr <= lq_rd[head_idx];
            bus.rf_wd <= lq_data[head_idx];
        end else begin
            bus.rf_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, ALU path, load drain, WAW kill,
// same-cycle conflict and queue wrap-around with x0 loads.
module tb_rf_writeback;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned LQ_DEPTH = 2;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rf_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(LQ_DEPTH)) bus ();

    rf_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd3;
        bus.ld_data  = 32'h0000_0033;
        step();
        step();
        vectors++; if (bus.ld_ready !== 1'b0) begin $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready); miscompares++; end
        vectors++; if (bus.rf_we !== 1'b0) begin $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); miscompares++; end
        vectors++; if (bus.rf_wr !== 5'd0 || bus.rf_wd !== 32'd0) begin $display("FAIL reset_rf_wr_wd: got %h/%h expected 00/00000000", bus.rf_wr, bus.rf_wd); miscompares++; end
        vectors++; if (bus.lq_count !== 2'd0) begin $display("FAIL reset_lq_count: got %0d expected 0", bus.lq_count); miscompares++; end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.ld_ready !== 1'b1) begin $display("FAIL release_ld_ready: got %b expected 1", bus.ld_ready); miscompares++; end
    endtask

    task automatic test_alu();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEAD_BEEF;
        step();
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd5 || bus.rf_wd !== 32'hDEAD_BEEF) begin $display("FAIL alu_write: got we=%b wr=%0d wd=%h expected we=1 wr=5 wd=deadbeef", bus.rf_we, bus.rf_wr, bus.rf_wd); miscompares++; end
        bus.alu_rd   = 5'd0;
        bus.alu_data = 32'h1234_5678;
        step();
        vectors++; if (bus.rf_we !== 1'b0 || bus.rf_wr !== 5'd5 || bus.rf_wd !== 32'hDEAD_BEEF) begin $display("FAIL alu_x0: got we=%b wr=%0d wd=%h expected we=0 wr=5 wd=deadbeef", bus.rf_we, bus.rf_wr, bus.rf_wd); miscompares++; end
        idle_inputs();
    endtask

    task automatic test_load_drain();
        bus.q_r1      = 5'd4;
        bus.q_r2      = 5'd3;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_data  = 32'h0000_0077;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd3;
        bus.ld_data   = 32'h0000_0011;
        step();
        vectors++; if (bus.lq_count !== 2'd1 || bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd7) begin $display("FAIL ld_first: got cnt=%0d we=%b wr=%0d expected cnt=1 we=1 wr=7", bus.lq_count, bus.rf_we, bus.rf_wr); miscompares++; end
        bus.ld_rd   = 5'd4;
        bus.ld_data = 32'h0000_0022;
        step();
        vectors++; if (bus.lq_count !== 2'd2 || bus.ld_ready !== 1'b0) begin $display("FAIL ld_full: got cnt=%0d ready=%b expected cnt=2 ready=0", bus.lq_count, bus.ld_ready); miscompares++; end
        vectors++; if (bus.pend1 !== 1'b1 || bus.pend2 !== 1'b1) begin $display("FAIL ld_pend: got pend1=%b pend2=%b expected 1/1", bus.pend1, bus.pend2); miscompares++; end
        idle_inputs();
        step();
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd3 || bus.rf_wd !== 32'h11 || bus.lq_count !== 2'd1 || bus.ld_ready !== 1'b1) begin $display("FAIL drain_1: got we=%b wr=%0d wd=%h cnt=%0d ready=%b expected 1/3/11/1/1", bus.rf_we, bus.rf_wr, bus.rf_wd, bus.lq_count, bus.ld_ready); miscompares++; end
        vectors++; if (bus.pend2 !== 1'b0 || bus.pend1 !== 1'b1) begin $display("FAIL drain_pend: got pend1=%b pend2=%b expected 1/0", bus.pend1, bus.pend2); miscompares++; end
        step();
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd4 || bus.rf_wd !== 32'h22 || bus.lq_count !== 2'd0) begin $display("FAIL drain_2: got we=%b wr=%0d wd=%h cnt=%0d expected 1/4/22/0", bus.rf_we, bus.rf_wr, bus.rf_wd, bus.lq_count); miscompares++; end
        step();
        vectors++; if (bus.rf_we !== 1'b0 || bus.pend1 !== 1'b0) begin $display("FAIL drain_idle: got we=%b pend1=%b expected 0/0", bus.rf_we, bus.pend1); miscompares++; end
    endtask

    task automatic test_waw_kill();
        bus.q_r1      = 5'd9;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd8;
        bus.alu_data  = 32'h0000_0088;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd9;
        bus.ld_data   = 32'h0000_0099;
        step();
        vectors++; if (bus.lq_count !== 2'd1 || bus.pend1 !== 1'b1) begin $display("FAIL waw_enq: got cnt=%0d pend1=%b expected 1/1", bus.lq_count, bus.pend1); miscompares++; end
        bus.ld_valid = 1'b0;
        bus.alu_rd   = 5'd9;
        bus.alu_data = 32'h0000_00AA;
        step();
        vectors++; if (bus.rf_wr !== 5'd9 || bus.rf_wd !== 32'hAA || bus.pend1 !== 1'b0 || bus.lq_count !== 2'd1) begin $display("FAIL waw_kill: got wr=%0d wd=%h pend1=%b cnt=%0d expected 9/aa/0/1", bus.rf_wr, bus.rf_wd, bus.pend1, bus.lq_count); miscompares++; end
        idle_inputs();
        step();
        vectors++; if (bus.rf_we !== 1'b0 || bus.rf_wd !== 32'hAA || bus.lq_count !== 2'd0) begin $display("FAIL waw_pop_dead: got we=%b wd=%h cnt=%0d expected 0/aa/0", bus.rf_we, bus.rf_wd, bus.lq_count); miscompares++; end
    endtask

    task automatic test_conflict();
        bus.q_r1      = 5'd6;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd6;
        bus.alu_data  = 32'h0000_0060;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd6;
        bus.ld_data   = 32'h0000_0066;
        step();
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd6 || bus.rf_wd !== 32'h60 || bus.lq_count !== 2'd1 || bus.pend1 !== 1'b0) begin $display("FAIL conflict: got we=%b wr=%0d wd=%h cnt=%0d pend1=%b expected 1/6/60/1/0", bus.rf_we, bus.rf_wr, bus.rf_wd, bus.lq_count, bus.pend1); miscompares++; end
        idle_inputs();
        step();
        vectors++; if (bus.rf_we !== 1'b0 || bus.lq_count !== 2'd0) begin $display("FAIL conflict_pop: got we=%b cnt=%0d expected 0/0", bus.rf_we, bus.lq_count); miscompares++; end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  st_rd   [8] = '{5'd12, 5'd13, 5'd0, 5'd14, 5'd15, 5'd0, 5'd16, 5'd17};
        logic [1:0]  st_cnt  [8] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
        logic [4:0]  exp_rd  [7] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
        logic [31:0] exp_wd  [7] = '{32'h111, 32'h200, 32'h201, 32'h203, 32'h204, 32'h206, 32'h207};
        int nwr;
        nwr = 0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd10;
        bus.alu_data  = 32'h0000_0100;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd11;
        bus.ld_data   = 32'h0000_0111;
        step();
        vectors++; if (bus.lq_count !== 2'd1 || bus.rf_wr !== 5'd10) begin $display("FAIL b2b_prime: got cnt=%0d wr=%0d expected 1/10", bus.lq_count, bus.rf_wr); miscompares++; end
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                bus.ld_valid = 1'b1;
                bus.ld_rd    = st_rd[i];
                bus.ld_data  = 32'h200 + 32'(i);
            end else begin
                idle_inputs();
            end
            step();
            if (i < 8) begin
                vectors++; if (bus.lq_count !== st_cnt[i]) begin $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, bus.lq_count, st_cnt[i]); miscompares++; end
            end
            if (bus.rf_we === 1'b1) begin
                vectors++;
                if (nwr >= 7 || bus.rf_wr === 5'd0) begin
                    $display("FAIL b2b_extra_write: got wr=%0d wd=%h expected no write", bus.rf_wr, bus.rf_wd); miscompares++;
                end else if (bus.rf_wr !== exp_rd[nwr] || bus.rf_wd !== exp_wd[nwr]) begin
                    $display("FAIL b2b_order[%0d]: got %0d/%h expected %0d/%h", nwr, bus.rf_wr, bus.rf_wd, exp_rd[nwr], exp_wd[nwr]); miscompares++;
                end
                nwr++;
            end
        end
        vectors++; if (nwr != 7 || bus.lq_count !== 2'd0) begin $display("FAIL b2b_total: got writes=%0d cnt=%0d expected 7/0", nwr, bus.lq_count); miscompares++; end
    endtask

    task automatic test_reset_mid();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd20;
        bus.alu_data  = 32'h0000_0020;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd21;
        bus.ld_data   = 32'h0000_0021;
        bus.q_r1      = 5'd21;
        step();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.lq_count !== 2'd0 || bus.pend1 !== 1'b0 || bus.rf_we !== 1'b0) begin $display("FAIL reset_mid: got cnt=%0d pend1=%b we=%b expected 0/0/0", bus.lq_count, bus.pend1, bus.rf_we); miscompares++; end
        step();
        vectors++; if (bus.rf_we !== 1'b0) begin $display("FAIL reset_mid_write: got we=%b expected 0", bus.rf_we); miscompares++; end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.q_r1    = '0;
        bus.q_r2    = '0;
        idle_inputs();
        test_reset();
        test_alu();
        test_load_drain();
        test_waw_kill();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side driver for the CPU register file's single write port (WE/wR/WD).
- Merges two result producers into one registered write stream:
  - the single-cycle ALU path, which is never stalled;
  - the multi-cycle load path, which is buffered in a small in-order load queue (LQ).
- Drops writes to x0.
- Enforces write-after-write ordering between ALU and load results to the same register.
- Exposes pending-load hazard flags for the decode stage's two read addresses.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- LQ_DEPTH, 2, load queue entries (power of two, ≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- alu_valid  input  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- ld_valid  input  1  load result offered.
- ld_ready  output  1  load result accepted when ld_valid&&ld_ready.
- ld_rd  input  ADDR_W  load destination register.
- ld_data  input  DATA_W  load data.
- rf_we  output  1  register file write enable (registered).
- rf_wr  output  ADDR_W  register file write index (registered).
- rf_wd  output  DATA_W  register file write data (registered).
- q_r1  input  ADDR_W  decode read address 1.
- q_r2  input  ADDR_W  decode read address 2.
- pend1  output  1  a live LQ entry targets q_r1 (combinational).
- pend2  output  1  a live LQ entry targets q_r2 (combinational).
- lq_count  output  $clog2(LQ_DEPTH)+1  occupied LQ entries, including killed entries.

Behaviour:
- Reset (rst_n=0 at posedge):
  - rf_we=0, rf_wr=0, rf_wd=0.
  - LQ emptied: head=tail=0, all live bits cleared.
  - lq_count=0.
  - ld_ready=0 while rst_n=0.
  - Reset mid-operation discards all queued loads with no write issued.
- ld_ready:
  - ld_ready = rst_n && (lq_count != LQ_DEPTH).
  - ld_ready does not depend on ld_valid and does not look ahead at a same-cycle pop.
- Enqueue, on handshake:
  - ld_rd==0 → handshake completes, nothing enqueued.
  - Otherwise write {rd,data,live=1} at tail.
  - If alu_valid && alu_rd==ld_rd in the same cycle, the new entry is enqueued with live=0 (the ALU result is younger and wins).
- Issue, one write per cycle, decided combinationally and registered at posedge (latency 1 cycle from input to rf_*):
  - Priority 1: alu_valid && alu_rd!=0 → rf_we=1, rf_wr=alu_rd, rf_wd=alu_data. LQ is not popped.
  - Priority 2: else LQ non-empty → pop head. Head live → rf_we=1 with head rd/data. Head killed → rf_we=0 (slot consumed, no write).
  - Otherwise rf_we=0; rf_wr and rf_wd hold their previous values.
  - alu_valid with alu_rd==0 counts as no ALU request, so an LQ pop may occur that cycle.
- Kill (WAW):
  - Whenever an ALU write to rd!=0 is issued, every live LQ entry with matching rd has live cleared at the same posedge.
- Simultaneous enqueue and pop: both occur; lq_count is unchanged.
- Pointers wrap modulo LQ_DEPTH. lq_count = tail−head over a (log2+1)-bit range.
- pend1:
  - pend1 = OR over live entries of (entry.rd==q_r1), and q_r1!=0.
  - pend2 is computed the same way using q_r2.
  - Killed entries never assert pend.
- x0 is never written by this block under any input.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with ld_valid=1 → ld_ready=0, rf_we=0, lq_count=0. Release → ld_ready=1.
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF → next cycle rf_we=1, rf_wr=5, rf_wd=0xDEADBEEF. alu_rd=0 → rf_we=0.
- Load drain and full:
  - Load rd=3 data=0x11, then rd=4 data=0x22, with alu_valid held 1 (rd=7) → lq_count=2, ld_ready=0, pend1=1 for q_r1=4.
  - Drop alu_valid → rf writes 3/0x11, then 4/0x22 on consecutive cycles; lq_count returns to 0; ld_ready goes high after the first pop.
- WAW kill:
  - Enqueue load rd=9 while ALU busy, then ALU writes rd=9 data=0xAA → pend(q=9) drops to 0 next cycle.
  - When idle, the head pops with rf_we=0; rf holds 0xAA semantics.
- Same-cycle conflict: ld handshake rd=6 and alu rd=6 together → ALU write issued, entry enqueued killed, lq_count=1, no later write to 6.
- Simultaneous enqueue/pop at LQ_DEPTH−1 occupancy with pointer wrap-around → FIFO order preserved across 8 random loads; load-to-x0 never writes.
